// File: rtl/acc_bus_pkg.sv
// rtl/acc_bus_pkg.sv - shared types and constants for the accumulator bus master
package acc_bus_pkg;

    localparam int DW_DEF      = 8;
    localparam int MAX_OPS_DEF = 15;
    localparam int CNT_W       = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_WFIRST,
        S_WNEXT,
        S_RD,
        S_DONE
    } state_e;

endpackage

// File: rtl/acc_bus_drv.sv
// rtl/acc_bus_drv.sv - tristate driver and sampler for the shared Dio bus
module acc_bus_drv #(
    parameter int DW = 8
) (
    input  logic          en_i,
    input  logic [DW-1:0] data_i,
    output logic [DW-1:0] sample_o,
    inout  wire  [DW-1:0] bus_io
);

    assign bus_io   = en_i ? data_i : {DW{1'bz}};
    assign sample_o = bus_io;

endmodule

// File: rtl/acc_bus_master.sv
// rtl/acc_bus_master.sv - bus initiator that streams operands into the accumulator and reads the sum back
module acc_bus_master
    import acc_bus_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int MAX_OPS = MAX_OPS_DEF
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             OpValid,
    input  logic [DW-1:0]    OpData,
    input  logic             OpLast,
    output logic             OpReady,
    output logic             Sel,
    output logic             RnW,
    inout  wire  [DW-1:0]    Dio,
    output logic             ResValid,
    output logic [DW-1:0]    ResData,
    output logic [CNT_W-1:0] ResCount,
    output logic             ResCarry,
    output logic             ResErr,
    input  logic             ResAck
);

    state_e           state_q, state_d;
    logic [DW-1:0]    shadow_q, shadow_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             carry_q, carry_d;
    logic             res_valid_q, res_valid_d;
    logic [DW-1:0]    res_data_q, res_data_d;
    logic [CNT_W-1:0] res_count_q, res_count_d;
    logic             res_carry_q, res_carry_d;
    logic             res_err_q, res_err_d;
    logic [DW-1:0]    bus_rd;
    logic [DW:0]      sum_ext;

    acc_bus_drv #(.DW(DW)) u_drv (
        .en_i     (Sel && !RnW),
        .data_i   (OpData),
        .sample_o (bus_rd),
        .bus_io   (Dio)
    );

    // Extra bit catches the modular wrap the peripheral silently performs.
    assign sum_ext = {1'b0, shadow_q} + {1'b0, OpData};

    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        count_d     = count_q;
        carry_d     = carry_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_count_d = res_count_q;
        res_carry_d = res_carry_q;
        res_err_d   = res_err_q;
        Sel         = 1'b0;
        RnW         = 1'b1;
        OpReady     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (OpValid) state_d = S_CLR;
            end
            S_CLR: begin
                Sel     = 1'b1;
                state_d = S_WFIRST;
            end
            S_WFIRST: begin
                Sel      = 1'b1;
                RnW      = 1'b0;
                OpReady  = 1'b1;
                shadow_d = OpData;
                count_d  = CNT_W'(1);
                carry_d  = 1'b0;
                state_d  = OpLast ? S_RD : S_WNEXT;
            end
            S_WNEXT: begin
                Sel     = OpValid;
                RnW     = 1'b0;
                OpReady = OpValid;
                if (OpValid) begin
                    shadow_d = sum_ext[DW-1:0];
                    carry_d  = carry_q | sum_ext[DW];
                    count_d  = count_q + CNT_W'(1);
                    if (OpLast || count_q == CNT_W'(MAX_OPS - 1)) state_d = S_RD;
                end
            end
            S_RD: begin
                Sel         = 1'b1;
                res_data_d  = bus_rd;
                res_err_d   = (bus_rd != shadow_q);
                res_count_d = count_q;
                res_carry_d = carry_q;
                res_valid_d = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE: begin
                if (ResAck) begin
                    res_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= S_IDLE;
            shadow_q    <= '0;
            count_q     <= '0;
            carry_q     <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_count_q <= '0;
            res_carry_q <= 1'b0;
            res_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            count_q     <= count_d;
            carry_q     <= carry_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_count_q <= res_count_d;
            res_carry_q <= res_carry_d;
            res_err_q   <= res_err_d;
        end
    end

    assign ResValid = res_valid_q;
    assign ResData  = res_data_q;
    assign ResCount = res_count_q;
    assign ResCarry = res_carry_q;
    assign ResErr   = res_err_q;

endmodule

// File: tb/tb_acc_bus_master.sv
// tb/tb_acc_bus_master.sv - directed bench for acc_bus_master with an accumulator responder
module tb_acc_bus_master;

    logic       Clk;
    logic       Rst;
    logic       OpValid;
    logic [7:0] OpData;
    logic       OpLast;
    logic       OpReady;
    logic       Sel;
    logic       RnW;
    wire  [7:0] dio;
    logic       ResValid;
    logic [7:0] ResData;
    logic [3:0] ResCount;
    logic       ResCarry;
    logic       ResErr;
    logic       ResAck;

    int n_checks = 0;
    int n_fail   = 0;

    acc_bus_master dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .OpValid  (OpValid),
        .OpData   (OpData),
        .OpLast   (OpLast),
        .OpReady  (OpReady),
        .Sel      (Sel),
        .RnW      (RnW),
        .Dio      (dio),
        .ResValid (ResValid),
        .ResData  (ResData),
        .ResCount (ResCount),
        .ResCarry (ResCarry),
        .ResErr   (ResErr),
        .ResAck   (ResAck)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Accumulator peripheral: a read arms load, the very next selected write loads.
    logic [7:0] per_sum  = 8'h00;
    logic       per_load = 1'b0;
    logic       corrupt;

    assign dio = (Sel && RnW) ? (corrupt ? 8'hFF : per_sum) : 8'hzz;

    always @(posedge Clk) begin
        if (Sel && RnW) begin
            per_load <= 1'b1;
        end else begin
            per_load <= 1'b0;
            if (Sel) per_sum <= per_load ? dio : per_sum + dio;
        end
    end

    // Bus activity counters; gaps are deselected cycles between a write and the read.
    int   wr_cnt   = 0;
    int   rd_cnt   = 0;
    int   gap_cnt  = 0;
    logic after_wr = 1'b0;

    always @(posedge Clk) begin
        if (Rst) begin
            after_wr <= 1'b0;
        end else if (Sel && !RnW) begin
            wr_cnt   <= wr_cnt + 1;
            after_wr <= 1'b1;
        end else if (Sel && RnW) begin
            rd_cnt   <= rd_cnt + 1;
            after_wr <= 1'b0;
        end else if (after_wr) begin
            gap_cnt  <= gap_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic op(input logic [7:0] d, input logic l);
        int n;
        OpValid = 1'b1;
        OpData  = d;
        OpLast  = l;
        n = 0;
        #1;
        while (!OpReady && n < 20) begin
            @(negedge Clk);
            #1;
            n++;
        end
        if (!OpReady) chk("op_timeout", {15'd0, OpReady}, 16'd1);
        @(negedge Clk);
        OpValid = 1'b0;
        OpLast  = 1'b0;
    endtask

    task automatic res_check(input string tag, input logic [7:0] d, input logic [3:0] c,
                             input logic cy, input logic e, input int hold);
        int n;
        n = 0;
        while (!ResValid && n < 40) begin
            @(negedge Clk);
            n++;
        end
        chk({tag, "_valid"}, {15'd0, ResValid}, 16'd1);
        chk({tag, "_data"},  {8'd0, ResData},   {8'd0, d});
        chk({tag, "_count"}, {12'd0, ResCount}, {12'd0, c});
        chk({tag, "_carry"}, {15'd0, ResCarry}, {15'd0, cy});
        chk({tag, "_err"},   {15'd0, ResErr},   {15'd0, e});
        if (hold > 0) begin
            OpValid = 1'b1;
            OpData  = 8'h01;
            for (int i = 0; i < hold; i++) begin
                @(negedge Clk);
                #1;
                chk({tag, "_hold_valid"}, {15'd0, ResValid}, 16'd1);
                chk({tag, "_hold_ready"}, {15'd0, OpReady},  16'd0);
            end
            OpValid = 1'b0;
            @(negedge Clk);
        end
        ResAck = 1'b1;
        @(negedge Clk);
        ResAck = 1'b0;
        chk({tag, "_acked"}, {15'd0, ResValid}, 16'd0);
        @(negedge Clk);
    endtask

    int w0, r0, g0;

    initial begin
        Rst     = 1'b1;
        OpValid = 1'b0;
        OpData  = 8'h00;
        OpLast  = 1'b0;
        ResAck  = 1'b0;
        corrupt = 1'b0;
        repeat (2) @(negedge Clk);
        chk("rst_sel",      {15'd0, Sel},      16'd0);
        chk("rst_rnw",      {15'd0, RnW},      16'd1);
        chk("rst_ready",    {15'd0, OpReady},  16'd0);
        chk("rst_valid",    {15'd0, ResValid}, 16'd0);
        chk("rst_data",     {8'd0, ResData},   16'd0);
        chk("rst_count",    {12'd0, ResCount}, 16'd0);
        chk("rst_carry",    {15'd0, ResCarry}, 16'd0);
        chk("rst_err",      {15'd0, ResErr},   16'd0);
        Rst = 1'b0;
        @(negedge Clk);

        // 5, 7, 9 back-to-back: CLR, three writes, RD, result one cycle later
        w0 = wr_cnt; r0 = rd_cnt; g0 = gap_cnt;
        op(8'd5, 1'b0);
        op(8'd7, 1'b0);
        op(8'd9, 1'b1);
        chk("t1_rd_sel",    {15'd0, Sel},      16'd1);
        chk("t1_rd_rnw",    {15'd0, RnW},      16'd1);
        chk("t1_rd_valid",  {15'd0, ResValid}, 16'd0);
        @(negedge Clk);
        chk("t1_lat_valid", {15'd0, ResValid}, 16'd1);
        chk("t1_writes",    16'(wr_cnt - w0),  16'd3);
        chk("t1_reads",     16'(rd_cnt - r0),  16'd2);
        chk("t1_gaps",      16'(gap_cnt - g0), 16'd0);
        chk("t1_done_sel",  {15'd0, Sel},      16'd0);
        res_check("t1", 8'd21, 4'd3, 1'b0, 1'b0, 0);

        // Leave 0x55 in the peripheral, then a single op must load, not add
        op(8'h55, 1'b1);
        res_check("t2a", 8'h55, 4'd1, 1'b0, 1'b0, 0);
        op(8'h3C, 1'b1);
        res_check("t2b", 8'h3C, 4'd1, 1'b0, 1'b0, 0);

        // 200 + 100 wraps to 44 with carry
        op(8'd200, 1'b0);
        op(8'd100, 1'b1);
        res_check("t3", 8'd44, 4'd2, 1'b1, 1'b0, 0);

        // Source stalls for 3 cycles mid-transaction
        g0 = gap_cnt;
        op(8'd1, 1'b0);
        repeat (3) @(negedge Clk);
        op(8'd2, 1'b0);
        op(8'd3, 1'b1);
        res_check("t4", 8'd6, 4'd3, 1'b0, 1'b0, 0);
        chk("t4_gaps",      16'(gap_cnt - g0), 16'd3);

        // 15 operands without OpLast force the read; result held without ack
        for (int i = 0; i < 15; i++) op(8'd1, 1'b0);
        res_check("t5", 8'd15, 4'd15, 1'b0, 1'b0, 10);

        // Reset during the second write of 4, 4, 4
        op(8'd4, 1'b0);
        OpValid = 1'b1;
        OpData  = 8'd4;
        Rst     = 1'b1;
        #1;
        chk("t6_wr_sel",    {15'd0, Sel},      16'd1);
        @(negedge Clk);
        chk("t6_rst_sel",   {15'd0, Sel},      16'd0);
        chk("t6_rst_rnw",   {15'd0, RnW},      16'd1);
        chk("t6_rst_valid", {15'd0, ResValid}, 16'd0);
        chk("t6_rst_ready", {15'd0, OpReady},  16'd0);
        Rst     = 1'b0;
        OpValid = 1'b0;
        @(negedge Clk);
        op(8'd2, 1'b0);
        op(8'd2, 1'b1);
        res_check("t6", 8'd4, 4'd2, 1'b0, 1'b0, 0);

        // Responder returns 0xFF instead of 0x10
        corrupt = 1'b1;
        op(8'h10, 1'b1);
        res_check("t7", 8'hFF, 4'd1, 1'b0, 1'b1, 0);
        corrupt = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
